l1_mmu_arbiter: RTL and testbench
=================================

// Module: l1_mmu_arbiter
// PURPOSE
//  Shares the single MMU line port between the L1 instruction cache (read-only) and the L1 data cache (read/write).
//  Sits between both L1 caches and the MMU; grants one requester at a time, muxes request/address/data down and
//  routes done/read data back. Keeps a D-cache dirty write-back and its following refill atomic; flags hung MMU transfers.
// PARAMETERS
//  ADDR_W     32    request address width
//  LINE_W     256   cache line width (MMIO uses bits [31:0])
//  TIMEOUT    1023  cycles a granted transfer may wait for mmu_done before err_timeout sets; 0 disables watchdog
// PORTS
//  sys_clk        in   1       clock, all state on posedge
//  rst_n          in   1       asynchronous, active-low reset
//  i_req_read     in   1       I-cache line read request, level, held until i_done
//  i_req_addr     in   ADDR_W  I-cache request address
//  i_done         out  1       one-cycle completion to I-cache
//  i_read_data    out  LINE_W  line data to I-cache, valid with i_done
//  d_req_read     in   1       D-cache read request (line fill or MMIO load)
//  d_req_write    in   1       D-cache write request (dirty write-back or MMIO store)
//  d_req_addr     in   ADDR_W  D-cache request address
//  d_write_data   in   LINE_W  D-cache write data
//  d_done         out  1       one-cycle completion to D-cache
//  d_read_data    out  LINE_W  line data to D-cache, valid with d_done
//  mmu_req_read   out  1       to MMU
//  mmu_req_write  out  1       to MMU
//  mmu_req_addr   out  ADDR_W  to MMU
//  mmu_write_data out  LINE_W  to MMU
//  mmu_done       in   1       MMU completion pulse, one cycle
//  mmu_read_data  in   LINE_W  MMU read data, valid with mmu_done
//  err_timeout    out  1       sticky watchdog flag
// BEHAVIOUR
//  - States: IDLE, GNT_I, GNT_D, D_LOCK. Reset: IDLE; all outputs 0; err_timeout 0; priority pointer -> D.
//  - IDLE: no request -> IDLE. Only I -> GNT_I. Only D (read or write) -> GNT_D. Both -> fixed priority D
//    (see CONFIGURATION). Grant takes effect the cycle after the request is seen (1-cycle arbitration latency).
//  - GNT_x: mmu_req_*/addr/write_data driven from granted requester only; other side's requests masked to 0.
//    mmu_done -> x_done=1 same cycle (combinational route), x_read_data=mmu_read_data; other side's done stays 0.
//    On mmu_done: GNT_I -> IDLE; GNT_D with d_req_write -> D_LOCK; GNT_D with read -> IDLE.
//  - D_LOCK (1 cycle): if d_req_read asserted -> GNT_D (refill follows write-back, I cannot interleave);
//    else -> IDLE. I requests wait.
//  - Requester dropping its request while granted without mmu_done: grant held until mmu_done (MMU owns transfer).
//  - mmu_done in IDLE or D_LOCK: ignored, no done routed.
//  - d_req_read and d_req_write both high: write wins (write-back before fill).
//  - Watchdog: counter clears on every grant change and mmu_done; counts while in GNT_x; reaching TIMEOUT sets
//    err_timeout (sticky until reset); counter saturates; arbitration unaffected.
//  - Reset mid-transfer: grant dropped immediately; MMU is reset by the same rst_n.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined: simultaneous I/D requests in IDLE go to the side not granted last; pointer updates
//   on each grant (D_LOCK re-grant does not flip it).
//  Not defined: D always wins simultaneous requests; no pointer register.
// STRUCTURE
//  Shared package: state encoding constants (IDLE/GNT_I/GNT_D/D_LOCK), requester ID constants, LINE_W/ADDR_W defaults.
//  One sub-module: l1_mmu_arb_wdog (watchdog counter + sticky flag). Muxing and FSM stay in top.
// TESTING
//  1. I read 0x0040_0020 alone -> mmu_req_read=1/addr=0x0040_0020 one cycle later; mmu_done -> i_done=1, d_done=0.
//  2. I and D read same cycle, macro off -> D granted; I granted after d_done; macro on, last=D -> I granted first.
//  3. D write 0x1000_0000 then read 0x2000_0000, I pending -> write, D_LOCK, D read, then I; no I grant between.
//  4. mmu_done pulsed in IDLE -> no i_done/d_done; state stays IDLE.
//  5. TIMEOUT=8, grant D, withhold mmu_done 8 cycles -> err_timeout=1, stays 1 after later mmu_done.
//  6. rst_n low mid GNT_D -> all outputs 0 asynchronously, state IDLE, err_timeout 0.

Source files
------------

// File: rtl/l1_mmu_arbiter_pkg.sv
// l1_mmu_arbiter_pkg
//   Shared definitions for the L1 <-> MMU line-port arbiter.
//   - arb_state_e : arbiter FSM encoding (IDLE, GNT_I, GNT_D, D_LOCK)
//   - REQ_I/REQ_D : requester IDs, used by the optional round-robin pointer
//   - ADDR_W_DEF / LINE_W_DEF : default address and line widths
package l1_mmu_arbiter_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int LINE_W_DEF = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_I  = 2'd1,
    GNT_D  = 2'd2,
    D_LOCK = 2'd3
  } arb_state_e;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/l1_mmu_arb_wdog.sv
// l1_mmu_arb_wdog
//   Watchdog for a granted MMU transfer. Counts cycles while a grant is
//   active, restarts on every clear, saturates at TIMEOUT and sets a sticky
//   error flag when TIMEOUT is reached. TIMEOUT = 0 disables the flag.
// Ports
//   sys_clk     in  clock
//   rst_n       in  asynchronous active-low reset
//   active      in  a requester currently holds the grant
//   clear       in  grant change or mmu_done this cycle
//   err_timeout out sticky timeout flag
module l1_mmu_arb_wdog #(
  parameter int TIMEOUT = 1023
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic active,
  input  logic clear,
  output logic err_timeout
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMAX = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (clear) begin
      cnt_d = '0;
    end else if (active && (cnt_q != TMAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    // Flag on the edge the count arrives at TIMEOUT; the counter then holds.
    if ((TIMEOUT != 0) && active && !clear && (cnt_d == TMAX)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_timeout = err_q;

endmodule

// File: rtl/l1_mmu_arbiter.sv
// l1_mmu_arbiter
//   Shares the single MMU line port between the L1 I-cache (read only) and
//   the L1 D-cache (read/write). One requester is granted at a time, one
//   cycle after its request is seen. A D-cache write-back is followed by a
//   one-cycle D_LOCK so that a refill read re-grants D before I can win.
//   Optional feature macro: ARB_ROUND_ROBIN_EN -- simultaneous requests in
//   IDLE go to the side not granted last. Without it D always wins.
// Ports
//   sys_clk, rst_n                     clock, async active-low reset
//   i_req_read/i_req_addr              I-cache request (level)
//   i_done/i_read_data                 I-cache completion and line data
//   d_req_read/d_req_write/d_req_addr  D-cache request (level)
//   d_write_data                       D-cache write data
//   d_done/d_read_data                 D-cache completion and line data
//   mmu_req_read/write/addr/write_data request towards MMU
//   mmu_done/mmu_read_data             MMU completion and read data
//   err_timeout                        sticky hung-transfer flag
module l1_mmu_arbiter
  import l1_mmu_arbiter_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int LINE_W  = LINE_W_DEF,
  parameter int TIMEOUT = 1023
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              i_req_read,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_done,
  output logic [LINE_W-1:0] i_read_data,
  input  logic              d_req_read,
  input  logic              d_req_write,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [LINE_W-1:0] d_write_data,
  output logic              d_done,
  output logic [LINE_W-1:0] d_read_data,
  output logic              mmu_req_read,
  output logic              mmu_req_write,
  output logic [ADDR_W-1:0] mmu_req_addr,
  output logic [LINE_W-1:0] mmu_write_data,
  input  logic              mmu_done,
  input  logic [LINE_W-1:0] mmu_read_data,
  output logic              err_timeout
);

  arb_state_e state_q, state_d;
  logic       d_any;

  assign d_any = d_req_read | d_req_write;

`ifdef ARB_ROUND_ROBIN_EN
  // ID of the requester granted last from IDLE; resets to D so I wins the
  // first tie.
  logic last_q, last_d;
`endif

  always_comb begin
    state_d = state_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (d_any && i_req_read) begin
`ifdef ARB_ROUND_ROBIN_EN
          state_d = (last_q == REQ_D) ? GNT_I : GNT_D;
`else
          state_d = GNT_D;
`endif
        end else if (d_any) begin
          state_d = GNT_D;
        end else if (i_req_read) begin
          state_d = GNT_I;
        end
      end
      GNT_I: begin
        if (mmu_done) state_d = IDLE;
      end
      GNT_D: begin
        if (mmu_done) state_d = d_req_write ? D_LOCK : IDLE;
      end
      D_LOCK: begin
        state_d = d_req_read ? GNT_D : IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef ARB_ROUND_ROBIN_EN
    // Only grants issued from IDLE move the pointer; the D_LOCK re-grant
    // is the tail of the same D transaction.
    if (state_q == IDLE && state_d == GNT_I) last_d = REQ_I;
    if (state_q == IDLE && state_d == GNT_D) last_d = REQ_D;
`endif
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
`ifdef ARB_ROUND_ROBIN_EN
      last_q  <= REQ_D;
`endif
    end else begin
      state_q <= state_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q  <= last_d;
`endif
    end
  end

  // Request mux and done routing depend only on the registered grant, so
  // the async reset of state_q forces every output low at once. The request
  // lines follow the granted requester's level; the grant itself is held
  // until mmu_done even if the requester lets go.
  always_comb begin
    mmu_req_read   = 1'b0;
    mmu_req_write  = 1'b0;
    mmu_req_addr   = '0;
    mmu_write_data = '0;
    i_done         = 1'b0;
    i_read_data    = '0;
    d_done         = 1'b0;
    d_read_data    = '0;
    unique case (state_q)
      GNT_I: begin
        mmu_req_read = i_req_read;
        mmu_req_addr = i_req_addr;
        i_done       = mmu_done;
        if (mmu_done) i_read_data = mmu_read_data;
      end
      GNT_D: begin
        // Write-back goes before fill when both are raised.
        mmu_req_write  = d_req_write;
        mmu_req_read   = d_req_read & ~d_req_write;
        mmu_req_addr   = d_req_addr;
        mmu_write_data = d_write_data;
        d_done         = mmu_done;
        if (mmu_done) d_read_data = mmu_read_data;
      end
      default: ;
    endcase
  end

  logic wd_active, wd_clear;

  assign wd_active = (state_q == GNT_I) || (state_q == GNT_D);
  assign wd_clear  = (state_d != state_q) || mmu_done;

  l1_mmu_arb_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .active     (wd_active),
    .clear      (wd_clear),
    .err_timeout(err_timeout)
  );

endmodule

// File: tb/tb_l1_mmu_arbiter.sv
module tb_l1_mmu_arbiter;

  localparam int ADDR_W  = 32;
  localparam int LINE_W  = 256;
  localparam int TIMEOUT = 8;

  localparam logic [31:0] IA = 32'h0040_0020;
  localparam logic [31:0] DA = 32'h3000_0040;
  localparam logic [31:0] WA = 32'h1000_0000;
  localparam logic [31:0] RA = 32'h2000_0000;

  logic              sys_clk = 1'b0;
  logic              rst_n;
  logic              i_req_read;
  logic [ADDR_W-1:0] i_req_addr;
  logic              i_done;
  logic [LINE_W-1:0] i_read_data;
  logic              d_req_read;
  logic              d_req_write;
  logic [ADDR_W-1:0] d_req_addr;
  logic [LINE_W-1:0] d_write_data;
  logic              d_done;
  logic [LINE_W-1:0] d_read_data;
  logic              mmu_req_read;
  logic              mmu_req_write;
  logic [ADDR_W-1:0] mmu_req_addr;
  logic [LINE_W-1:0] mmu_write_data;
  logic              mmu_done;
  logic [LINE_W-1:0] mmu_read_data;
  logic              err_timeout;

  logic [LINE_W-1:0] wd_pat;
  logic [LINE_W-1:0] rd_pat;

  always #5 sys_clk = ~sys_clk;

  l1_mmu_arbiter #(
    .ADDR_W (ADDR_W),
    .LINE_W (LINE_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .sys_clk       (sys_clk),
    .rst_n         (rst_n),
    .i_req_read    (i_req_read),
    .i_req_addr    (i_req_addr),
    .i_done        (i_done),
    .i_read_data   (i_read_data),
    .d_req_read    (d_req_read),
    .d_req_write   (d_req_write),
    .d_req_addr    (d_req_addr),
    .d_write_data  (d_write_data),
    .d_done        (d_done),
    .d_read_data   (d_read_data),
    .mmu_req_read  (mmu_req_read),
    .mmu_req_write (mmu_req_write),
    .mmu_req_addr  (mmu_req_addr),
    .mmu_write_data(mmu_write_data),
    .mmu_done      (mmu_done),
    .mmu_read_data (mmu_read_data),
    .err_timeout   (err_timeout)
  );

  typedef struct {
    logic        ir, dr, dw, md;
    logic [31:0] da;
    logic        e_mr, e_mw;
    logic [31:0] e_addr;
    logic        e_id, e_dd, e_dsel;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input logic ir, input logic dr, input logic dw, input logic md,
                     input logic [31:0] da, input logic e_mr, input logic e_mw,
                     input logic [31:0] e_addr, input logic e_id, input logic e_dd,
                     input logic e_dsel);
    vec_t v;
    v.ir = ir; v.dr = dr; v.dw = dw; v.md = md; v.da = da;
    v.e_mr = e_mr; v.e_mw = e_mw; v.e_addr = e_addr;
    v.e_id = e_id; v.e_dd = e_dd; v.e_dsel = e_dsel;
    vecs.push_back(v);
  endtask

  // Compare every output against the expected grant picture.
  task automatic chk(input string name, input logic e_mr, input logic e_mw,
                     input logic [31:0] e_addr, input logic e_id, input logic e_dd,
                     input logic e_dsel, input logic e_err);
    logic [LINE_W-1:0] e_wdata, e_ird, e_drd;
    logic              ok;
    e_wdata = e_dsel ? wd_pat : '0;
    e_ird   = e_id ? rd_pat : '0;
    e_drd   = e_dd ? rd_pat : '0;
    ok = (mmu_req_read === e_mr) && (mmu_req_write === e_mw) &&
         (mmu_req_addr === e_addr) && (i_done === e_id) && (d_done === e_dd) &&
         (mmu_write_data === e_wdata) && (i_read_data === e_ird) &&
         (d_read_data === e_drd) && (err_timeout === e_err);
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got mr=%b mw=%b addr=%h id=%b dd=%b err=%b wdat_ok=%b ird_ok=%b drd_ok=%b; want mr=%b mw=%b addr=%h id=%b dd=%b err=%b",
               name, mmu_req_read, mmu_req_write, mmu_req_addr, i_done, d_done, err_timeout,
               mmu_write_data === e_wdata, i_read_data === e_ird, d_read_data === e_drd,
               e_mr, e_mw, e_addr, e_id, e_dd, e_err);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic dr, input logic dw, input logic md,
                       input logic [31:0] da);
    i_req_read  = ir;
    d_req_read  = dr;
    d_req_write = dw;
    mmu_done    = md;
    d_req_addr  = da;
  endtask

  initial begin
    wd_pat        = {8{32'h1234_5678}};
    rd_pat        = {8{32'hCAFE_F00D}};
    rst_n         = 1'b0;
    i_req_addr    = IA;
    d_write_data  = wd_pat;
    mmu_read_data = rd_pat;
    drive(0, 0, 0, 0, 32'h0);

    // ir dr dw md  daddr   | mr mw addr  id dd dsel
    add(0, 0, 0, 0, 32'h0,   0, 0, 32'h0, 0, 0, 0);
    // simultaneous I and D reads from reset
    add(1, 1, 0, 0, DA,      0, 0, 32'h0, 0, 0, 0);
`ifdef ARB_ROUND_ROBIN_EN
    add(1, 1, 0, 0, DA,      1, 0, IA,    0, 0, 0);
    add(1, 1, 0, 1, DA,      1, 0, IA,    1, 0, 0);
    add(0, 1, 0, 0, DA,      0, 0, 32'h0, 0, 0, 0);
    add(0, 1, 0, 1, DA,      1, 0, DA,    0, 1, 1);
`else
    add(1, 1, 0, 0, DA,      1, 0, DA,    0, 0, 1);
    add(1, 1, 0, 1, DA,      1, 0, DA,    0, 1, 1);
    add(1, 0, 0, 0, DA,      0, 0, 32'h0, 0, 0, 0);
    add(1, 0, 0, 1, DA,      1, 0, IA,    1, 0, 0);
`endif
    add(0, 0, 0, 0, 32'h0,   0, 0, 32'h0, 0, 0, 0);
    // lone I read
    add(1, 0, 0, 0, 32'h0,   0, 0, 32'h0, 0, 0, 0);
    add(1, 0, 0, 0, 32'h0,   1, 0, IA,    0, 0, 0);
    add(1, 0, 0, 1, 32'h0,   1, 0, IA,    1, 0, 0);
    add(0, 0, 0, 0, 32'h0,   0, 0, 32'h0, 0, 0, 0);
    // stray mmu_done in IDLE
    add(0, 0, 0, 1, 32'h0,   0, 0, 32'h0, 0, 0, 0);
    add(1, 0, 0, 0, 32'h0,   0, 0, 32'h0, 0, 0, 0);
    add(1, 0, 0, 1, 32'h0,   1, 0, IA,    1, 0, 0);
    add(0, 0, 0, 0, 32'h0,   0, 0, 32'h0, 0, 0, 0);
    // write-back (read+write raised: write wins), D_LOCK, refill, then I
    add(1, 1, 1, 0, WA,      0, 0, 32'h0, 0, 0, 0);
    add(1, 1, 1, 1, WA,      0, 1, WA,    0, 1, 1);
    add(1, 1, 0, 0, RA,      0, 0, 32'h0, 0, 0, 0);
    add(1, 1, 0, 1, RA,      1, 0, RA,    0, 1, 1);
    add(1, 0, 0, 0, 32'h0,   0, 0, 32'h0, 0, 0, 0);
    add(1, 0, 0, 1, 32'h0,   1, 0, IA,    1, 0, 0);
    add(0, 0, 0, 0, 32'h0,   0, 0, 32'h0, 0, 0, 0);
    // write-back with no refill: D_LOCK falls back to IDLE
    add(0, 0, 1, 0, WA,      0, 0, 32'h0, 0, 0, 0);
    add(0, 0, 1, 1, WA,      0, 1, WA,    0, 1, 1);
    add(0, 0, 0, 0, 32'h0,   0, 0, 32'h0, 0, 0, 0);
    add(1, 0, 0, 0, 32'h0,   0, 0, 32'h0, 0, 0, 0);
    add(1, 0, 0, 1, 32'h0,   1, 0, IA,    1, 0, 0);
    add(0, 0, 0, 0, 32'h0,   0, 0, 32'h0, 0, 0, 0);
    // D drops its request while granted: grant held until mmu_done
    add(0, 1, 0, 0, RA,      0, 0, 32'h0, 0, 0, 0);
    add(1, 0, 0, 0, RA,      0, 0, RA,    0, 0, 1);
    add(1, 0, 0, 1, RA,      0, 0, RA,    0, 1, 1);
    add(1, 0, 0, 0, 32'h0,   0, 0, 32'h0, 0, 0, 0);
    add(1, 0, 0, 1, 32'h0,   1, 0, IA,    1, 0, 0);
    add(0, 0, 0, 0, 32'h0,   0, 0, 32'h0, 0, 0, 0);

    repeat (2) @(posedge sys_clk);
    #1;
    chk("reset_state", 0, 0, 32'h0, 0, 0, 0, 0);
    @(negedge sys_clk);
    rst_n = 1'b1;

    for (int k = 0; k < vecs.size(); k++) begin
      @(posedge sys_clk);
      #1;
      drive(vecs[k].ir, vecs[k].dr, vecs[k].dw, vecs[k].md, vecs[k].da);
      @(negedge sys_clk);
      chk($sformatf("vec%0d", k), vecs[k].e_mr, vecs[k].e_mw, vecs[k].e_addr,
          vecs[k].e_id, vecs[k].e_dd, vecs[k].e_dsel, 1'b0);
    end

    // Watchdog: grant D and withhold mmu_done for TIMEOUT cycles.
    @(posedge sys_clk);
    #1;
    drive(0, 1, 0, 0, RA);
    @(posedge sys_clk);  // grant edge
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(posedge sys_clk);
      #1;
      if (k == TIMEOUT - 1) chk_bit("wdog_before", err_timeout, 1'b0);
      if (k == TIMEOUT)     chk_bit("wdog_set", err_timeout, 1'b1);
    end
    chk("wdog_grant_kept", 1, 0, RA, 0, 0, 1, 1);
    drive(0, 1, 0, 1, RA);
    @(posedge sys_clk);
    #1;
    drive(0, 0, 0, 0, 32'h0);
    @(negedge sys_clk);
    chk("wdog_sticky", 0, 0, 32'h0, 0, 0, 0, 1);

    // Asynchronous reset in the middle of a D grant.
    @(posedge sys_clk);
    #1;
    drive(0, 1, 0, 0, RA);
    @(posedge sys_clk);
    #1;
    mmu_done = 1'b1;
    #1;
    chk("pre_reset_gnt_d", 1, 0, RA, 0, 1, 1, 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset", 0, 0, 32'h0, 0, 0, 0, 0);
    mmu_done = 1'b0;
    @(negedge sys_clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 32'h0);
    @(posedge sys_clk);
    #1;
    drive(1, 0, 0, 0, 32'h0);
    @(negedge sys_clk);
    chk("post_reset_idle", 0, 0, 32'h0, 0, 0, 0, 0);
    @(posedge sys_clk);
    #1;
    chk("post_reset_gnt_i", 1, 0, IA, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
